radar_frame_sequencer: RTL and testbench

//  Frame-level controller in front of the radar processor queue. Admits whole chirp packets from the ADC

---
 rtl/radar_frame_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_radar_frame_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : radar_frame_sequencer
// Description : Frame-level controller in front of the radar processor queue.
//               It admits whole chirp packets from the ADC packet stream and
//               groups them into frames of CHIRPS_PER_FRAME chirps. It writes
//               the two SDRAM corner-turn banks in ping-pong order and drops
//               whole chirps when no bank is free. It reports frame
//               start/done/abort events and drop statistics.
// Optional    : define SEQ_TIMESTAMP_EN to add a free-running 32-bit cycle
//               counter and the opFrameTimestamp output. That output holds
//               the counter value captured at each frame start.
// Ports       : ipClk/ipReset        clock, async active-low reset
//               ipEnable             level, arms the sequencer
//               ipPacket_*           chirp packet stream in (no backpressure)
//               opPacket_*           gated packet stream out, 1-cycle latency
//               ipReadoutDone/Bank   corner turn released a bank
//               opBank, opBankBusy   bank being written / per-bank busy flags
//               opFrameStart/Done/Abort  1-cycle frame event pulses
//               opChirpIndex         index of chirp being forwarded
//               opFrameCount, opDropCount  saturating statistics
// Revision    : 1.0  initial release
// ============================================================================
module radar_frame_sequencer #(
    parameter int CHIRPS_PER_FRAME = 128,
    parameter int DATA_WIDTH       = 14,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                                ipClk,
    input  logic                                ipReset,
    input  logic                                ipEnable,
    input  logic                                ipPacket_SoP,
    input  logic                                ipPacket_EoP,
    input  logic [DATA_WIDTH-1:0]               ipPacket_Data,
    input  logic                                ipPacket_Valid,
    output logic                                opPacket_SoP,
    output logic                                opPacket_EoP,
    output logic [DATA_WIDTH-1:0]               opPacket_Data,
    output logic                                opPacket_Valid,
    input  logic                                ipReadoutDone,
    input  logic                                ipReadoutBank,
    output logic                                opBank,
    output logic                                opFrameStart,
    output logic                                opFrameDone,
    output logic                                opFrameAbort,
    output logic [$clog2(CHIRPS_PER_FRAME)-1:0] opChirpIndex,
    output logic [COUNT_WIDTH-1:0]              opFrameCount,
    output logic [COUNT_WIDTH-1:0]              opDropCount,
    output logic [1:0]                          opBankBusy
`ifdef SEQ_TIMESTAMP_EN
    ,
    output logic [31:0]                         opFrameTimestamp
`endif
);

    localparam int                   IDX_WIDTH  = $clog2(CHIRPS_PER_FRAME);
    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(CHIRPS_PER_FRAME - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BANK = 3'd1,
        S_ARMED     = 3'd2,
        S_CHIRP     = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t r_state;

    logic                 w_sop;
    logic                 w_admit;
    logic                 w_inChirp;
    logic                 w_malformed;
    logic                 w_fwd;
    logic                 w_chirpEnd;
    logic                 w_lastChirp;
    logic                 w_countDrop;
    logic [IDX_WIDTH-1:0] w_curIdx;

    assign w_sop       = ipPacket_Valid & ipPacket_SoP;
    // New chirps are only accepted between chirps of an armed sequencer.
    assign w_admit     = w_sop & ipEnable & ((r_state == S_ARMED) | (r_state == S_GAP));
    // Inside an admitted chirp, forwarding continues to EoP even if disabled.
    assign w_inChirp   = (r_state == S_CHIRP) & ipPacket_Valid;
    // A second SoP before EoP closes the frame; the new chirp is dropped.
    assign w_malformed = w_inChirp & ipPacket_SoP;
    assign w_fwd       = w_admit | (w_inChirp & ~ipPacket_SoP);
    assign w_chirpEnd  = w_fwd & ipPacket_EoP;
    // In ARMED the chirp about to start is chirp 0; GAP already holds the next index.
    assign w_curIdx    = (r_state == S_ARMED) ? '0 : opChirpIndex;
    assign w_lastChirp = (w_curIdx == c_LAST_IDX);
    // Dropped chirps are counted only while the sequencer is enabled.
    assign w_countDrop = w_sop & ~w_admit & ipEnable;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            r_state        <= S_IDLE;
            opPacket_SoP   <= 1'b0;
            opPacket_EoP   <= 1'b0;
            opPacket_Data  <= '0;
            opPacket_Valid <= 1'b0;
            opBank         <= 1'b0;
            opFrameStart   <= 1'b0;
            opFrameDone    <= 1'b0;
            opFrameAbort   <= 1'b0;
            opChirpIndex   <= '0;
            opFrameCount   <= '0;
            opDropCount    <= '0;
            opBankBusy     <= 2'b00;
        end else begin
            opFrameStart   <= 1'b0;
            opFrameDone    <= 1'b0;
            opFrameAbort   <= 1'b0;
            opPacket_Valid <= w_fwd;
            opPacket_SoP   <= w_fwd & ipPacket_SoP;
            opPacket_EoP   <= w_fwd & ipPacket_EoP;
            opPacket_Data  <= w_fwd ? ipPacket_Data : '0;

            if (w_countDrop && (opDropCount != {COUNT_WIDTH{1'b1}})) begin
                opDropCount <= opDropCount + 1'b1;
            end

            // Readout clear first; a later set of the same bit in this block wins.
            if (ipReadoutDone) begin
                opBankBusy[ipReadoutBank] <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (ipEnable) begin
                        r_state <= S_WAIT_BANK;
                    end
                end
                S_WAIT_BANK: begin
                    if (!ipEnable) begin
                        r_state <= S_IDLE;
                    end else if (!opBankBusy[opBank]) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!ipEnable) begin
                        r_state <= S_IDLE;
                    end else if (w_admit) begin
                        opFrameStart       <= 1'b1;
                        opBankBusy[opBank] <= 1'b1;
                        opChirpIndex       <= '0;
                        r_state            <= S_CHIRP;
                    end
                end
                S_GAP: begin
                    if (!ipEnable) begin
                        // A frame is always partial here: abandon it.
                        opFrameAbort       <= 1'b1;
                        opBankBusy[opBank] <= 1'b0;
                        opChirpIndex       <= '0;
                        r_state            <= S_IDLE;
                    end else if (w_admit) begin
                        r_state <= S_CHIRP;
                    end
                end
                S_CHIRP: begin
                    if (w_malformed) begin
                        opFrameAbort       <= 1'b1;
                        opBankBusy[opBank] <= 1'b0;
                        opChirpIndex       <= '0;
                        r_state            <= ipEnable ? S_WAIT_BANK : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Common end-of-chirp handling; also covers single-sample chirps
            // admitted straight from ARMED or GAP.
            if (w_chirpEnd) begin
                if (w_lastChirp) begin
                    opFrameDone  <= 1'b1;
                    opBank       <= ~opBank;
                    opChirpIndex <= '0;
                    r_state      <= ipEnable ? S_WAIT_BANK : S_IDLE;
                    if (opFrameCount != {COUNT_WIDTH{1'b1}}) begin
                        opFrameCount <= opFrameCount + 1'b1;
                    end
                end else if (!ipEnable) begin
                    opFrameAbort       <= 1'b1;
                    opBankBusy[opBank] <= 1'b0;
                    opChirpIndex       <= '0;
                    r_state            <= S_IDLE;
                end else begin
                    opChirpIndex <= w_curIdx + 1'b1;
                    r_state      <= S_GAP;
                end
            end
        end
    end

`ifdef SEQ_TIMESTAMP_EN
    logic [31:0] r_cycleCount;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            r_cycleCount     <= 32'd0;
            opFrameTimestamp <= 32'd0;
        end else begin
            r_cycleCount <= r_cycleCount + 32'd1;
            if (w_admit && (r_state == S_ARMED)) begin
                opFrameTimestamp <= r_cycleCount;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_radar_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_radar_frame_sequencer
// Description : Directed self-checking bench for radar_frame_sequencer with
//               CHIRPS_PER_FRAME=4. It covers frame fill, bank ping-pong,
//               drops while both banks are busy, disable mid-chirp, a
//               malformed SoP, readout coinciding with frame done, and
//               asynchronous reset mid-chirp.
// Revision    : 1.0  initial release
// ============================================================================
module tb_radar_frame_sequencer;

    localparam int CPF = 4;
    localparam int DW  = 14;
    localparam int CW  = 16;

    logic          clk;
    logic          ipReset;
    logic          ipEnable;
    logic          ipPacket_SoP;
    logic          ipPacket_EoP;
    logic [DW-1:0] ipPacket_Data;
    logic          ipPacket_Valid;
    logic          opPacket_SoP;
    logic          opPacket_EoP;
    logic [DW-1:0] opPacket_Data;
    logic          opPacket_Valid;
    logic          ipReadoutDone;
    logic          ipReadoutBank;
    logic          opBank;
    logic          opFrameStart;
    logic          opFrameDone;
    logic          opFrameAbort;
    logic [1:0]    opChirpIndex;
    logic [CW-1:0] opFrameCount;
    logic [CW-1:0] opDropCount;
    logic [1:0]    opBankBusy;
`ifdef SEQ_TIMESTAMP_EN
    logic [31:0]   opFrameTimestamp;
`endif

    int tests = 0;
    int fails = 0;

    radar_frame_sequencer #(
        .CHIRPS_PER_FRAME (CPF),
        .DATA_WIDTH       (DW),
        .COUNT_WIDTH      (CW)
    ) dut (
        .ipClk            (clk),
        .ipReset          (ipReset),
        .ipEnable         (ipEnable),
        .ipPacket_SoP     (ipPacket_SoP),
        .ipPacket_EoP     (ipPacket_EoP),
        .ipPacket_Data    (ipPacket_Data),
        .ipPacket_Valid   (ipPacket_Valid),
        .opPacket_SoP     (opPacket_SoP),
        .opPacket_EoP     (opPacket_EoP),
        .opPacket_Data    (opPacket_Data),
        .opPacket_Valid   (opPacket_Valid),
        .ipReadoutDone    (ipReadoutDone),
        .ipReadoutBank    (ipReadoutBank),
        .opBank           (opBank),
        .opFrameStart     (opFrameStart),
        .opFrameDone      (opFrameDone),
        .opFrameAbort     (opFrameAbort),
        .opChirpIndex     (opChirpIndex),
        .opFrameCount     (opFrameCount),
        .opDropCount      (opDropCount),
        .opBankBusy       (opBankBusy)
`ifdef SEQ_TIMESTAMP_EN
        ,
        .opFrameTimestamp (opFrameTimestamp)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one input sample, advance one clock, return #1 after the edge,
    // where the outputs show the registered result for that sample.
    task automatic drive(input bit sop, input bit eop, input bit valid, input int data);
        ipPacket_SoP   = sop;
        ipPacket_EoP   = eop;
        ipPacket_Valid = valid;
        ipPacket_Data  = DW'(data);
        @(posedge clk);
        #1;
        ipPacket_SoP   = 1'b0;
        ipPacket_EoP   = 1'b0;
        ipPacket_Valid = 1'b0;
        ipReadoutDone  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    // Send an n-sample chirp and check every output sample.
    task automatic sendChirp(input string tag, input int n, input int base, input bit expFwd,
                             input bit expStart, input bit expDone, input bit expAbort,
                             input int expIdx, input int disableAt, input bit readoutAtEnd,
                             input bit readoutBank);
        for (int i = 0; i < n; i++) begin
            if (i == disableAt) ipEnable = 1'b0;
            if (readoutAtEnd && i == n - 1) begin
                ipReadoutDone = 1'b1;
                ipReadoutBank = readoutBank;
            end
            drive(i == 0, i == n - 1, 1'b1, base + i);
            check({tag, ".valid"}, 32'(opPacket_Valid), 32'(expFwd));
            if (expFwd) begin
                check({tag, ".data"}, 32'(opPacket_Data), 32'(DW'(base + i)));
                check({tag, ".sop"}, 32'(opPacket_SoP), 32'(i == 0));
                check({tag, ".eop"}, 32'(opPacket_EoP), 32'(i == n - 1));
            end
            if (i == 0) begin
                check({tag, ".start"}, 32'(opFrameStart), 32'(expStart));
                if (expFwd) check({tag, ".idx"}, 32'(opChirpIndex), 32'(expIdx));
            end
            if (i == n - 1) begin
                check({tag, ".done"}, 32'(opFrameDone), 32'(expDone));
                check({tag, ".abort"}, 32'(opFrameAbort), 32'(expAbort));
            end
        end
    endtask

    initial begin
        ipReset        = 1'b0;
        ipEnable       = 1'b0;
        ipPacket_SoP   = 1'b0;
        ipPacket_EoP   = 1'b0;
        ipPacket_Data  = '0;
        ipPacket_Valid = 1'b0;
        ipReadoutDone  = 1'b0;
        ipReadoutBank  = 1'b0;

        // ---- reset state
        @(posedge clk);
        #1;
        check("rst.valid", 32'(opPacket_Valid), 0);
        check("rst.bank", 32'(opBank), 0);
        check("rst.busy", 32'(opBankBusy), 0);
        check("rst.fcount", 32'(opFrameCount), 0);
        check("rst.dcount", 32'(opDropCount), 0);
        check("rst.idx", 32'(opChirpIndex), 0);
        ipReset = 1'b1;

        // ---- frame 1 into bank 0
        ipEnable = 1'b1;
        idle(3);
        for (int k = 0; k < CPF; k++)
            sendChirp("f1", 8, 16 * k, 1'b1, k == 0, k == CPF - 1, 1'b0, k, -1, 1'b0, 1'b0);
        check("f1.bank", 32'(opBank), 1);
        check("f1.fcount", 32'(opFrameCount), 1);
        check("f1.busy", 32'(opBankBusy), 32'h1);

        // ---- frame 2 into bank 1, then both banks busy
        idle(2);
        for (int k = 0; k < CPF; k++)
            sendChirp("f2", 8, 200 + 16 * k, 1'b1, k == 0, k == CPF - 1, 1'b0, k, -1, 1'b0, 1'b0);
        check("f2.bank", 32'(opBank), 0);
        check("f2.fcount", 32'(opFrameCount), 2);
        check("f2.busy", 32'(opBankBusy), 32'h3);

        // ---- no free bank: three chirps dropped
        for (int k = 0; k < 3; k++)
            sendChirp("drop", 4, 500 + 8 * k, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
        check("drop.dcount", 32'(opDropCount), 3);

        // ---- readout releases bank 0
        ipReadoutDone = 1'b1;
        ipReadoutBank = 1'b0;
        idle(1);
        check("rd0.busy", 32'(opBankBusy), 32'h2);
        idle(1);

        // ---- frame 3: disable mid chirp 2, chirp completes, then abort
        sendChirp("f3c0", 8, 1000, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
        check("f3.busy", 32'(opBankBusy), 32'h3);
        sendChirp("f3c1", 8, 1100, 1'b1, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0, 1'b0);
        sendChirp("f3c2", 8, 1200, 1'b1, 1'b0, 1'b0, 1'b1, 2, 4, 1'b0, 1'b0);
        check("dis.busy", 32'(opBankBusy), 32'h2);
        check("dis.bank", 32'(opBank), 0);
        check("dis.idx", 32'(opChirpIndex), 0);
        check("dis.fcount", 32'(opFrameCount), 2);
        idle(1);
        sendChirp("dis.drop", 4, 1300, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);

        // ---- malformed: second SoP without EoP
        ipEnable = 1'b1;
        idle(3);
        drive(1'b1, 1'b0, 1'b1, 100);
        check("mal.start", 32'(opFrameStart), 1);
        check("mal.v0", 32'(opPacket_Valid), 1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 100 + i);
            check("mal.vmid", 32'(opPacket_Valid), 1);
        end
        drive(1'b1, 1'b0, 1'b1, 200);
        check("mal.vsop2", 32'(opPacket_Valid), 0);
        check("mal.abort", 32'(opFrameAbort), 1);
        check("mal.dcount", 32'(opDropCount), 4);
        check("mal.busy", 32'(opBankBusy), 32'h2);
        check("mal.idx", 32'(opChirpIndex), 0);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, i == 3, 1'b1, 200 + i);
            check("mal.vrest", 32'(opPacket_Valid), 0);
        end

        // ---- frame 4 in bank 0, readout of bank 1 coincides with frame done
        idle(1);
        for (int k = 0; k < CPF; k++)
            sendChirp("f4", 8, 2000 + 16 * k, 1'b1, k == 0, k == CPF - 1, 1'b0, k, -1,
                      k == CPF - 1, 1'b1);
        check("f4.bank", 32'(opBank), 1);
        check("f4.busy", 32'(opBankBusy), 32'h1);
        check("f4.fcount", 32'(opFrameCount), 3);
        idle(1);
        check("f4.busy1", 32'(opBankBusy), 32'h1);

        // ---- frame 5 in bank 1, async reset mid chirp
        drive(1'b1, 1'b0, 1'b1, 3000);
        check("f5.start", 32'(opFrameStart), 1);
        check("f5.v0", 32'(opPacket_Valid), 1);
        check("f5.busy", 32'(opBankBusy), 32'h3);
        drive(1'b0, 1'b0, 1'b1, 3001);
        drive(1'b0, 1'b0, 1'b1, 3002);
        check("f5.v2", 32'(opPacket_Valid), 1);
        #2;
        ipReset = 1'b0;
        #1;
        check("arst.valid", 32'(opPacket_Valid), 0);
        check("arst.data", 32'(opPacket_Data), 0);
        check("arst.bank", 32'(opBank), 0);
        check("arst.busy", 32'(opBankBusy), 0);
        check("arst.fcount", 32'(opFrameCount), 0);
        check("arst.dcount", 32'(opDropCount), 0);
        @(posedge clk);
        #1;
        ipReset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 3003);
        check("post.vmid", 32'(opPacket_Valid), 0);
        drive(1'b0, 1'b1, 1'b1, 3004);
        check("post.veop", 32'(opPacket_Valid), 0);
        idle(1);
        sendChirp("post", 8, 4000, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
        check("post.bank", 32'(opBank), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
